// File: rtl/seven_segment_pkg.sv
// rtl/seven_segment_pkg.sv - shared constants, scan state type and hex segment table
package seven_segment_pkg;

    localparam logic [6:0] SEG_OFF = 7'h7F;
    localparam logic [3:0] AN_OFF  = 4'hF;

    typedef enum logic [0:0] {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } scan_state_t;

    // Active-low A..G (A in the MSB); element 15 is listed first.
    localparam logic [15:0][6:0] HEX_SEG = {
        7'h38, 7'h30, 7'h42, 7'h31, 7'h60, 7'h08, 7'h04, 7'h00,
        7'h0F, 7'h20, 7'h24, 7'h4C, 7'h06, 7'h12, 7'h4F, 7'h01
    };

endpackage

// File: rtl/seven_segment_decoder.sv
// rtl/seven_segment_decoder.sv - combinational hex nibble to active-low segment decode
module seven_segment_decoder
    import seven_segment_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    assign seg = HEX_SEG[hex];

endmodule

// File: rtl/seven_segment_scan_ctrl.sv
// rtl/seven_segment_scan_ctrl.sv - 4-digit multiplexed display scanner with frame-aligned updates
module seven_segment_scan_ctrl
    import seven_segment_pkg::*;
#(
    parameter int DIV_DRIVE = 100000,
    parameter int DIV_BLANK = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        upd_valid,
    output logic        upd_ready,
    input  logic [15:0] upd_value,
    input  logic [3:0]  upd_blank,
    input  logic [3:0]  upd_dp,
    output logic [0:3]  an,
    output logic [0:6]  seg,
    output logic        dp,
    output logic        frame_done
);

    localparam int CNT_MAX = (DIV_DRIVE > DIV_BLANK) ? DIV_DRIVE : DIV_BLANK;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(DIV_DRIVE - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(DIV_BLANK - 1);

    scan_state_t      state, nxt_state;
    logic [1:0]       idx, nxt_idx;
    logic [CNT_W-1:0] cnt, nxt_cnt;

    logic [15:0] pend_value, act_value;
    logic [3:0]  pend_blank, pend_dp, act_blank, act_dp;
    logic        pend;
    logic [3:0]  nxt_nibble;
    logic [6:0]  nxt_seg;

    // The pending flag is stored inverted so the ready output is a plain flop.
    assign pend = !upd_ready;

    always_comb begin
        nxt_state = state;
        nxt_idx   = idx;
        nxt_cnt   = cnt + CNT_W'(1);
        case (state)
            BLANK: begin
                if (cnt == BLANK_LAST) begin
                    nxt_state = DRIVE;
                    nxt_cnt   = '0;
                end
            end
            DRIVE: begin
                if (cnt == DRIVE_LAST) begin
                    nxt_state = BLANK;
                    nxt_cnt   = '0;
                    nxt_idx   = idx + 2'd1;
                end
            end
            default: begin
                nxt_state = BLANK;
                nxt_cnt   = '0;
            end
        endcase
    end

    assign nxt_nibble = act_value[nxt_idx*4 +: 4];

    seven_segment_decoder u_decoder (
        .hex (nxt_nibble),
        .seg (nxt_seg)
    );

    // Outputs are registered from the next scan position so they line up with the FSM.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= BLANK;
            idx        <= '0;
            cnt        <= '0;
            upd_ready  <= 1'b1;
            pend_value <= '0;
            pend_blank <= '0;
            pend_dp    <= '0;
            act_value  <= '0;
            act_blank  <= 4'hF;
            act_dp     <= '0;
            an         <= AN_OFF;
            seg        <= SEG_OFF;
            dp         <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            state <= nxt_state;
            idx   <= nxt_idx;
            cnt   <= nxt_cnt;

            // Promotion and capture are exclusive: capture needs pend clear, promotion needs it set.
            if (frame_done && pend) begin
                act_value <= pend_value;
                act_blank <= pend_blank;
                act_dp    <= pend_dp;
                upd_ready <= 1'b1;
            end else if (upd_valid && upd_ready) begin
                pend_value <= upd_value;
                pend_blank <= upd_blank;
                pend_dp    <= upd_dp;
                upd_ready  <= 1'b0;
            end

            frame_done <= (nxt_state == DRIVE) && (nxt_idx == 2'd3) && (nxt_cnt == DRIVE_LAST);

            if ((nxt_state == DRIVE) && !act_blank[nxt_idx]) begin
                an  <= ~(4'b1000 >> nxt_idx);
                seg <= nxt_seg;
                dp  <= !act_dp[nxt_idx];
            end else begin
                an  <= AN_OFF;
                seg <= SEG_OFF;
                dp  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seven_segment_scan_ctrl.sv
// tb/tb_seven_segment_scan_ctrl.sv - scoreboard bench for seven_segment_scan_ctrl
module tb_seven_segment_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        upd_valid;
    logic        upd_ready;
    logic [15:0] upd_value;
    logic [3:0]  upd_blank;
    logic [3:0]  upd_dp;
    logic [0:3]  an;
    logic [0:6]  seg;
    logic        dp;
    logic        frame_done;

    always #5 clk = ~clk;

    seven_segment_scan_ctrl #(
        .DIV_DRIVE (4),
        .DIV_BLANK (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .upd_valid  (upd_valid),
        .upd_ready  (upd_ready),
        .upd_value  (upd_value),
        .upd_blank  (upd_blank),
        .upd_dp     (upd_dp),
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .frame_done (frame_done)
    );

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       fd;
        logic       rdy;
    } obs_t;

    obs_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model: cycle number since reset release plus plain pending/active records.
    int          t = 0;
    bit          m_pend = 0;
    logic [15:0] pv, av;
    logic [3:0]  pb, pd, ab, ad;

    function automatic logic [6:0] hex_seg(input logic [3:0] h);
        case (h)
            4'h0: return 7'h01;  4'h1: return 7'h4F;  4'h2: return 7'h12;  4'h3: return 7'h06;
            4'h4: return 7'h4C;  4'h5: return 7'h24;  4'h6: return 7'h20;  4'h7: return 7'h0F;
            4'h8: return 7'h00;  4'h9: return 7'h04;  4'hA: return 7'h08;  4'hB: return 7'h60;
            4'hC: return 7'h31;  4'hD: return 7'h42;  4'hE: return 7'h30;  default: return 7'h38;
        endcase
    endfunction

    function automatic obs_t expect_at(input int cyc);
        obs_t e;
        int pos, d, r;
        pos = cyc % 24;
        d   = pos / 6;
        r   = pos % 6;
        e.an  = 4'hF;
        e.seg = 7'h7F;
        e.dp  = 1'b1;
        if (r >= 2 && !ab[d]) begin
            e.an  = ~(4'b1000 >> d);
            e.seg = hex_seg(av[d*4 +: 4]);
            e.dp  = !ad[d];
        end
        e.fd  = (pos == 23);
        e.rdy = !m_pend;
        return e;
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                t = 0; m_pend = 0; av = '0; ab = 4'hF; ad = '0;
            end else begin
                if ((t % 24) == 23 && m_pend) begin
                    av = pv; ab = pb; ad = pd; m_pend = 0;
                end else if (upd_valid && !m_pend) begin
                    pv = upd_value; pb = upd_blank; pd = upd_dp; m_pend = 1;
                end
                t++;
            end
            exp_q.push_back(expect_at(t));
        end
    end

    initial begin
        obs_t e, a;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = {an, seg, dp, frame_done, upd_ready};
                n_cmp++;
                if (a !== e) begin
                    n_bad++;
                    $display("FAIL outputs cycle=%0d got an=%b seg=%h dp=%b fd=%b rdy=%b exp an=%b seg=%h dp=%b fd=%b rdy=%b",
                             t, a.an, a.seg, a.dp, a.fd, a.rdy, e.an, e.seg, e.dp, e.fd, e.rdy);
                end
            end
        end
    end

    task automatic drive(input bit v, input logic [15:0] val, input logic [3:0] b,
                         input logic [3:0] d, input bit r);
        @(negedge clk);
        upd_valid = v; upd_value = val; upd_blank = b; upd_dp = d; rst = r;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(0, $urandom, $urandom, $urandom, 0);
    endtask

    task automatic drive_at(input int p, input bit v, input logic [15:0] val,
                            input logic [3:0] b, input logic [3:0] d, input bit r);
        bit hit = 0;
        for (int k = 0; k < 100 && !hit; k++) begin
            @(negedge clk);
            if ((t % 24) == p) begin
                upd_valid = v; upd_value = val; upd_blank = b; upd_dp = d; rst = r;
                hit = 1;
            end else begin
                upd_valid = 0; rst = 0;
            end
        end
        if (!hit) begin
            n_cmp++;
            n_bad++;
            $display("FAIL wait_pos got timeout exp pos=%0d", p);
        end
    endtask

    initial begin
        rst = 1; upd_valid = 0; upd_value = '0; upd_blank = '0; upd_dp = '0;
        repeat (3) @(negedge clk);
        rst = 0;
        // basic update at cycle 1, displayed in the second frame
        drive_at(1, 1, 16'h1234, 4'b0000, 4'b0100, 0);
        idle(50);
        // hex digits with digit 1 blanked
        drive_at(5, 1, 16'hABCD, 4'b0010, 4'b1001, 0);
        idle(50);
        // offer landing exactly on the frame_done cycle
        drive_at(23, 1, 16'h5678, 4'b0000, 4'b0001, 0);
        idle(60);
        // backpressure: valid held with a changing value
        drive_at(3, 1, 16'h1111, 4'b0000, 4'b0000, 0);
        repeat (40) drive(1, $urandom, $urandom_range(0, 3), $urandom, 0);
        idle(30);
        // mid-frame reset during digit 2 drive with an update pending
        drive_at(2, 1, 16'h9999, 4'b0000, 4'b1111, 0);
        drive_at(14, 0, 16'h0000, 4'b0000, 4'b0000, 1);
        idle(60);
        // randomized traffic with occasional resets
        for (int i = 0; i < 1500; i++)
            drive($urandom_range(0, 2) != 0, $urandom, $urandom_range(0, 15) < 3 ? $urandom : 4'h0,
                  $urandom, $urandom_range(0, 199) == 0);
        idle(3);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
